// File: rtl/fir_mac_sequencer_pkg.sv
// Shared constants for the FIR filter: state encodings and default geometry.
// Also used by the datapath and coefficient ROM.
package fir_pkg;

  localparam int unsigned DEF_TAPS    = 16;
  localparam int unsigned DEF_MUL_LAT = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DUMP  = 3'd4;

  // Tag that travels alongside a product through the multiplier pipeline.
  typedef struct packed {
    logic issue;
    logic first;
  } mac_tag_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Control bundle between the FIR sequencer (master) and the datapath/host (slave).
// tap_sel_mirror exists only when FIR_MAC_SEQUENCER_SYMMETRIC_EN is defined.
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = DEF_TAPS
);
  localparam int unsigned TAP_W = $clog2(TAPS);

  logic             sample_strobe;
  logic             overrun_clr;
  logic             shift_en;
  logic [TAP_W-1:0] tap_sel;
  logic             acc_clr;
  logic             acc_en;
  logic             out_en;
  logic             busy;
  logic             overrun;
`ifdef FIR_MAC_SEQUENCER_SYMMETRIC_EN
  logic [TAP_W-1:0] tap_sel_mirror;

  modport master (
    input  sample_strobe, overrun_clr,
    output shift_en, tap_sel, tap_sel_mirror, acc_clr, acc_en, out_en, busy, overrun
  );
  modport slave (
    output sample_strobe, overrun_clr,
    input  shift_en, tap_sel, tap_sel_mirror, acc_clr, acc_en, out_en, busy, overrun
  );
`else
  modport master (
    input  sample_strobe, overrun_clr,
    output shift_en, tap_sel, acc_clr, acc_en, out_en, busy, overrun
  );
  modport slave (
    output sample_strobe, overrun_clr,
    input  shift_en, tap_sel, acc_clr, acc_en, out_en, busy, overrun
  );
`endif

endinterface

// File: rtl/fir_mac_sequencer_pipe_delay.sv
// DEPTH-stage delay of the {issue, first} tag, matching the multiplier latency.
// DEPTH=0 is a plain wire.
module fir_pipe_delay
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MUL_LAT
) (
  input  logic     clk,
  input  logic     reset_n,
  input  mac_tag_t i_tag,
  output mac_tag_t o_tag
);

  if (DEPTH == 0) begin : g_bypass
    assign o_tag = i_tag;
  end else begin : g_pipe
    mac_tag_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_tag;
        for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_tag = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM time-multiplexing one MAC across all FIR taps; no datapath.
// FIR_MAC_SEQUENCER_SYMMETRIC_EN: half-length MAC phase plus mirrored tap index.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned TAPS    = DEF_TAPS,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input logic                 clk,
  input logic                 reset_n,
  fir_mac_sequencer_if.master bus
);

  localparam int unsigned TAP_W = $clog2(TAPS);
`ifdef FIR_MAC_SEQUENCER_SYMMETRIC_EN
  localparam int unsigned MAC_LEN = TAPS / 2;
`else
  localparam int unsigned MAC_LEN = TAPS;
`endif
  localparam logic [TAP_W-1:0] MAC_LAST    = TAP_W'(MAC_LEN - 1);
  localparam logic [TAP_W-1:0] MIRROR_BASE = TAP_W'(TAPS - 1);
  localparam logic [2:0]       DRAIN_LAST  = 3'((MUL_LAT == 0) ? 0 : MUL_LAT - 1);

  if (TAPS < 2) begin : g_chk_taps
    $error("fir_mac_sequencer: TAPS must be >= 2");
  end
  if (MUL_LAT > 7) begin : g_chk_lat
    $error("fir_mac_sequencer: MUL_LAT must be 0..7");
  end
`ifdef FIR_MAC_SEQUENCER_SYMMETRIC_EN
  if ((TAPS % 2) != 0) begin : g_chk_even
    $error("fir_mac_sequencer: symmetric mode needs even TAPS");
  end
`endif

  logic [2:0]       r_state;
  logic [TAP_W-1:0] r_tap_sel;
  logic [2:0]       r_drain_cnt;
  logic             r_shift_en;
  logic             r_issue;
  logic             r_first;
  logic             r_out_en;
  logic             r_busy;
  logic             r_overrun;

  logic [2:0]       w_next_state;
  logic [TAP_W-1:0] w_next_tap;
  logic [2:0]       w_next_drain;
  logic             w_drop;
  mac_tag_t         w_tag_in;
  mac_tag_t         w_tag_out;

  always_comb begin
    w_next_state = r_state;
    w_next_tap   = r_tap_sel;
    w_next_drain = r_drain_cnt;
    case (r_state)
      ST_IDLE:  if (bus.sample_strobe) w_next_state = ST_SHIFT;
      ST_SHIFT: begin
        w_next_state = ST_MAC;
        w_next_tap   = '0;
      end
      ST_MAC: begin
        if (r_tap_sel == MAC_LAST) begin
          w_next_state = (MUL_LAT > 0) ? ST_DRAIN : ST_DUMP;
          w_next_drain = '0;
        end else begin
          w_next_tap = r_tap_sel + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_next_state = ST_DUMP;
        else                           w_next_drain = r_drain_cnt + 3'd1;
      end
      ST_DUMP:  w_next_state = bus.sample_strobe ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // DUMP is excluded: a strobe there starts the next sample back-to-back.
  assign w_drop = bus.sample_strobe &&
                  ((r_state == ST_SHIFT) || (r_state == ST_MAC) || (r_state == ST_DRAIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_tap_sel   <= '0;
      r_drain_cnt <= '0;
      r_shift_en  <= 1'b0;
      r_issue     <= 1'b0;
      r_first     <= 1'b0;
      r_out_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_tap_sel   <= w_next_tap;
      r_drain_cnt <= w_next_drain;
      r_shift_en  <= (w_next_state == ST_SHIFT);
      r_issue     <= (w_next_state == ST_MAC);
      r_first     <= (w_next_state == ST_MAC) && (r_state == ST_SHIFT);
      r_out_en    <= (w_next_state == ST_DUMP);
      r_busy      <= (w_next_state != ST_IDLE);
      if (w_drop)                r_overrun <= 1'b1;
      else if (bus.overrun_clr)  r_overrun <= 1'b0;
    end
  end

  assign w_tag_in.issue = r_issue;
  assign w_tag_in.first = r_first;

  fir_pipe_delay #(
    .DEPTH (MUL_LAT)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

`ifdef FIR_MAC_SEQUENCER_SYMMETRIC_EN
  logic [TAP_W-1:0] r_tap_sel_mirror;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_tap_sel_mirror <= '0;
    else if (w_next_state == ST_MAC)    r_tap_sel_mirror <= MIRROR_BASE - w_next_tap;
  end

  assign bus.tap_sel_mirror = r_tap_sel_mirror;
`endif

  assign bus.shift_en = r_shift_en;
  assign bus.tap_sel  = r_tap_sel;
  assign bus.acc_en   = w_tag_out.issue;
  assign bus.acc_clr  = w_tag_out.issue && w_tag_out.first;
  assign bus.out_en   = r_out_en;
  assign bus.busy     = r_busy;
  assign bus.overrun  = r_overrun;

endmodule
